// File: rtl/red_pitaya_pwm_ramp.sv
// Slew-rate limiter between a setpoint register and the PWM signal input.
// Optional build macro PWM_RAMP_CLAMP_EN saturates writes to [LIM_LO, LIM_HI].
module red_pitaya_pwm_ramp #(
   parameter int                    DW     = 14,
   parameter int                    SW     = 13,
   parameter logic signed [DW-1:0]  LIM_LO = -14'sd8192,
   parameter logic signed [DW-1:0]  LIM_HI = 14'sd8191
)(
   input  logic                  clk,
   input  logic                  rstn,
   input  logic signed [DW-1:0]  target_i,
   input  logic                  target_we_i,
   input  logic [SW-1:0]         step_i,
   input  logic                  jump_i,
   input  logic                  sync_i,
   output logic signed [DW-1:0]  signal_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RAMP   = 2'd1;
   localparam logic [1:0] SETTLE = 2'd2;

   logic        [1:0]     state;
   logic        [1:0]     state_next;
   logic signed [DW-1:0]  target_r;
   logic signed [DW-1:0]  tgt_in;
   logic signed [DW-1:0]  tgt_next;
   logic signed [DW-1:0]  sig_next;
   logic        [DW:0]    diff;
   logic        [DW:0]    abs_diff;
   logic        [DW:0]    step_ext;
   logic        [DW:0]    sig_ext;
   logic        [DW:0]    sig_step;

`ifdef PWM_RAMP_CLAMP_EN
   always_comb begin
      tgt_in = target_i;
      if (target_i < LIM_LO)
         tgt_in = LIM_LO;
      else if (target_i > LIM_HI)
         tgt_in = LIM_HI;
   end
`else
   assign tgt_in = target_i;
`endif

   // One extra bit keeps the full-scale difference (e.g. 8191 - -8192) exact.
   assign sig_ext  = {signal_o[DW-1], signal_o};
   assign diff     = {target_r[DW-1], target_r} - sig_ext;
   assign abs_diff = diff[DW] ? (~diff + 1'b1) : diff;
   assign step_ext = (DW+1)'(step_i);
   assign sig_step = diff[DW] ? (sig_ext - step_ext) : (sig_ext + step_ext);

   always_comb begin
      sig_next = signal_o;
      if (sync_i) begin
         if (jump_i || (abs_diff <= step_ext))
            sig_next = target_r;
         else
            sig_next = sig_step[DW-1:0];
      end
   end

   assign tgt_next = target_we_i ? tgt_in : target_r;

   // Decisions look at post-edge target/signal so busy rises right after a write.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (tgt_next != sig_next)
               state_next = RAMP;
         end
         RAMP: begin
            if (sync_i && (sig_next == target_r))
               state_next = SETTLE;
            else if (tgt_next == sig_next)
               state_next = IDLE;
            else
               state_next = RAMP;
         end
         SETTLE: begin
            if (tgt_next != sig_next)
               state_next = RAMP;
            else
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         target_r <= '0;
         signal_o <= '0;
         state    <= IDLE;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
      end else begin
         if (target_we_i)
            target_r <= tgt_in;
         signal_o <= sig_next;
         state    <= state_next;
         busy_o   <= (state_next == RAMP);
         done_o   <= (state_next == SETTLE);
      end
   end

endmodule

// File: tb/tb_red_pitaya_pwm_ramp.sv
// Self-checking bench for red_pitaya_pwm_ramp: directed scenarios plus a
// randomized run against a behavioural model of the ramp.
module tb_red_pitaya_pwm_ramp;

   logic               clk = 1'b0;
   logic               rstn;
   logic signed [13:0] target_i;
   logic               target_we_i;
   logic [12:0]        step_i;
   logic               jump_i;
   logic               sync_i;
   logic signed [13:0] signal_o;
   logic               busy_o;
   logic               done_o;

   int checks = 0;
   int errors = 0;

   int   m_sig, m_tgt;
   logic m_busy, m_done;

   red_pitaya_pwm_ramp #(.DW(14), .SW(13), .LIM_LO(-14'sd8192), .LIM_HI(14'sd4000)) dut (
      .clk(clk), .rstn(rstn), .target_i(target_i), .target_we_i(target_we_i),
      .step_i(step_i), .jump_i(jump_i), .sync_i(sync_i),
      .signal_o(signal_o), .busy_o(busy_o), .done_o(done_o));

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   function automatic int sat(input int v);
`ifdef PWM_RAMP_CLAMP_EN
      if (v < -8192) return -8192;
      if (v > 4000) return 4000;
`endif
      return v;
   endfunction

   // Drive one cycle of inputs, let the edge happen, advance the model.
   task automatic drive(input logic r, input logic we, input int tgt, input int stp,
                        input logic jmp, input logic sy);
      int old_t, old_s, d, ad;
      rstn = r; target_we_i = we; target_i = tgt[13:0]; step_i = stp[12:0];
      jump_i = jmp; sync_i = sy;
      @(posedge clk);
      if (!r) begin
         m_sig = 0; m_tgt = 0; m_busy = 1'b0; m_done = 1'b0;
      end else begin
         old_t = m_tgt; old_s = m_sig;
         if (sy) begin
            d  = old_t - old_s;
            ad = (d < 0) ? -d : d;
            if (jmp || ad <= stp) m_sig = old_t;
            else m_sig = old_s + ((d > 0) ? stp : -stp);
         end
         if (we) m_tgt = sat(tgt);
         m_done = sy && (old_s != old_t) && (m_sig == old_t);
         m_busy = !m_done && (m_sig != m_tgt);
      end
      #1;
      target_we_i = 1'b0; sync_i = 1'b0; jump_i = 1'b0;
   endtask

   task automatic test_reset();
      drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
      checks++; if (signal_o !== 14'sd0) begin errors++; $display("[TB] FAIL reset_signal got %0d expected 0", signal_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy_o); end
      checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b expected 0", done_o); end
   endtask

   task automatic test_basic_ramp();
      int exp_v[4] = '{30, 60, 90, 100};
      int dones = 0;
      test_reset();
      drive(1'b1, 1'b1, 100, 30, 1'b0, 1'b0);
      checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_rise got %b expected 1", busy_o); end
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 0, 30, 1'b0, 1'b1);
         checks++; if (signal_o !== exp_v[i][13:0]) begin errors++; $display("[TB] FAIL basic_step%0d got %0d expected %0d", i, signal_o, exp_v[i]); end
         if (done_o === 1'b1) dones++;
         drive(1'b1, 1'b0, 0, 30, 1'b0, 1'b0);
         if (done_o === 1'b1) dones++;
      end
      checks++; if (dones != 1) begin errors++; $display("[TB] FAIL basic_done_count got %0d expected 1", dones); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_after got %b expected 0", busy_o); end
   endtask

   task automatic test_jump();
      drive(1'b1, 1'b1, -8192, 30, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 0, 30, 1'b1, 1'b1);
      checks++; if (signal_o !== -14'sd8192) begin errors++; $display("[TB] FAIL jump_full_scale got %0d expected -8192", signal_o); end
      checks++; if (done_o !== 1'b1) begin errors++; $display("[TB] FAIL jump_done got %b expected 1", done_o); end
   endtask

   task automatic test_reverse();
      int exp_v[3] = '{200, 100, 0};
      int dones = 0;
      test_reset();
      drive(1'b1, 1'b1, 1000, 100, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 0, 100, 1'b0, 1'b1);
         drive(1'b1, 1'b0, 0, 100, 1'b0, 1'b0);
      end
      checks++; if (signal_o !== 14'sd300) begin errors++; $display("[TB] FAIL reverse_pre got %0d expected 300", signal_o); end
      drive(1'b1, 1'b1, 0, 100, 1'b0, 1'b0);
      checks++; if (signal_o !== 14'sd300 || busy_o !== 1'b1) begin errors++; $display("[TB] FAIL reverse_retarget got %0d/%b expected 300/1", signal_o, busy_o); end
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 0, 100, 1'b0, 1'b1);
         checks++; if (signal_o !== exp_v[i][13:0]) begin errors++; $display("[TB] FAIL reverse_step%0d got %0d expected %0d", i, signal_o, exp_v[i]); end
         if (done_o === 1'b1) dones++;
         drive(1'b1, 1'b0, 0, 100, 1'b0, 1'b0);
         if (done_o === 1'b1) dones++;
      end
      checks++; if (dones != 1) begin errors++; $display("[TB] FAIL reverse_done_count got %0d expected 1", dones); end
   endtask

   task automatic test_same_cycle();
      test_reset();
      drive(1'b1, 1'b1, 50, 30, 1'b0, 1'b1);
      checks++; if (signal_o !== 14'sd0) begin errors++; $display("[TB] FAIL same_cycle_hold got %0d expected 0", signal_o); end
      drive(1'b1, 1'b0, 0, 30, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 0, 30, 1'b0, 1'b1);
      checks++; if (signal_o !== 14'sd30) begin errors++; $display("[TB] FAIL same_cycle_next got %0d expected 30", signal_o); end
   endtask

   task automatic test_step_zero();
      test_reset();
      drive(1'b1, 1'b1, 10, 0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
         drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
      end
      checks++; if (signal_o !== 14'sd0 || busy_o !== 1'b1) begin errors++; $display("[TB] FAIL step_zero got %0d/%b expected 0/1", signal_o, busy_o); end
      drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
      checks++; if (signal_o !== 14'sd0 || busy_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_ramp_reset got %0d/%b/%b expected 0/0/0", signal_o, busy_o, done_o); end
      drive(1'b1, 1'b0, 0, 5, 1'b0, 1'b1);
      checks++; if (signal_o !== 14'sd0 || busy_o !== 1'b0) begin errors++; $display("[TB] FAIL target_cleared got %0d/%b expected 0/0", signal_o, busy_o); end
   endtask

   task automatic test_clamp();
      int expect_v;
`ifdef PWM_RAMP_CLAMP_EN
      expect_v = 4000;
`else
      expect_v = 8000;
`endif
      test_reset();
      drive(1'b1, 1'b1, 8000, 10, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 0, 10, 1'b1, 1'b1);
      checks++; if (signal_o !== expect_v[13:0]) begin errors++; $display("[TB] FAIL clamp_jump got %0d expected %0d", signal_o, expect_v); end
   endtask

   task automatic test_random();
      logic last_sync = 1'b0;
      logic r, we, jmp, sy;
      int   tgt, stp;
      test_reset();
      stp = 100;
      for (int n = 0; n < 600; n++) begin
         r   = ($urandom_range(0, 99) != 0);
         we  = ($urandom_range(0, 7) == 0);
         tgt = int'($urandom_range(0, 16383)) - 8192;
         if ($urandom_range(0, 15) == 0)
            stp = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 3000));
         jmp = ($urandom_range(0, 15) == 0);
         sy  = !last_sync && ($urandom_range(0, 2) == 0);
         last_sync = sy;
         drive(r, we, tgt, stp, jmp, sy);
         checks++; if (signal_o !== m_sig[13:0]) begin errors++; $display("[TB] FAIL rand_signal cyc%0d got %0d expected %0d", n, signal_o, m_sig); end
         checks++; if (busy_o !== m_busy) begin errors++; $display("[TB] FAIL rand_busy cyc%0d got %b expected %b", n, busy_o, m_busy); end
         checks++; if (done_o !== m_done) begin errors++; $display("[TB] FAIL rand_done cyc%0d got %b expected %b", n, done_o, m_done); end
      end
   endtask

   initial begin
      rstn = 1'b0; target_we_i = 1'b0; target_i = '0; step_i = '0; jump_i = 1'b0; sync_i = 1'b0;
      m_sig = 0; m_tgt = 0; m_busy = 1'b0; m_done = 1'b0;
      test_reset();
      test_basic_ramp();
      test_jump();
      test_reverse();
      test_same_cycle();
      test_step_zero();
      test_clamp();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
